// File: rtl/soc_datamem_arb.sv
// soc_datamem_arb: two-master round-robin arbiter in front of a byte-addressed data memory
module soc_datamem_arb #(
  parameter int MEM_SIZE = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;
  logic win, start, sel, last, we_q, err_q, we_w, err_w;
  logic [1:0] size_q, off_q, size_w;
  logic [3:0] be_q, be_w;
  logic [31:0] addr_w, wdata_w, rd_sh, rd_w, rdata_q;
  always_comb begin
    win = (m0_req & m1_req) ? ~last : m1_req;
    start = (state == IDLE) & (m0_req | m1_req);
    we_w = win ? m1_we : m0_we;
    size_w = win ? m1_size : m0_size;
    addr_w = win ? m1_addr : m0_addr;
    wdata_w = win ? m1_wdata : m0_wdata;
    err_w = (size_w == 2'd3) | ((size_w == 2'd1) & addr_w[0]) |
            ((size_w == 2'd2) & (addr_w[1:0] != 2'd0)) | (addr_w > 32'(MEM_SIZE - 4));
    be_w = (size_w == 2'd0) ? 4'b0001 << addr_w[1:0] :
           (size_w == 2'd1) ? 4'b0011 << addr_w[1:0] : 4'b1111;
    state_nxt = start ? ACCESS : (state == ACCESS) ? RESP : IDLE;
    rd_sh = mem_rdata >> {off_q, 3'b000};
    rd_w = (we_q | err_q) ? 32'd0 :
           (size_q == 2'd0) ? {24'd0, rd_sh[7:0]} :
           (size_q == 2'd1) ? {16'd0, rd_sh[15:0]} : rd_sh;
  end
  // the pointer remembers the last winner so ties alternate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= 1'b1;
      sel <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= 2'd0;
      off_q <= 2'd0;
      be_q <= 4'd0;
      mem_addr <= 32'd0;
      mem_wdata <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (start) begin
        sel <= win;
        last <= win;
        we_q <= we_w;
        err_q <= err_w;
        size_q <= size_w;
        off_q <= addr_w[1:0];
        be_q <= be_w;
        mem_addr <= {addr_w[31:2], 2'b00};
        mem_wdata <= wdata_w << {addr_w[1:0], 3'b000};
      end
      if (state == ACCESS) rdata_q <= rd_w;
    end
  end
  assign m0_gnt = (state == ACCESS) & ~sel;
  assign m1_gnt = (state == ACCESS) & sel;
  assign m0_rvalid = (state == RESP) & ~sel;
  assign m1_rvalid = (state == RESP) & sel;
  assign m0_rdata = m0_rvalid ? rdata_q : 32'd0;
  assign m1_rdata = m1_rvalid ? rdata_q : 32'd0;
  assign m0_err = m0_rvalid & err_q;
  assign m1_err = m1_rvalid & err_q;
  assign mem_wen = ((state == ACCESS) & we_q & ~err_q) ? be_q : 4'b0000;
endmodule

// File: tb/tb_soc_datamem_arb.sv
// tb_soc_datamem_arb: directed vectors, corner sequences and randomized traffic vs a byte-level memory model
module tb_soc_datamem_arb;
  localparam int MEM = 4096;
  typedef struct {
    bit we;
    logic [1:0] size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tx_t;
  typedef struct {
    int m;
    tx_t x;
    logic [3:0] wen;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    bit err;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [1:0] m0_size = 0, m1_size = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wen;
  logic [7:0] mem [MEM];
  logic [7:0] ref_mem [MEM];
  bit ref_last = 1'b1;
  int n_cmp = 0, n_fail = 0;
  vec_t vt [8];
  tx_t t [2];
  bit pend [2];

  soc_datamem_arb #(.MEM_SIZE(MEM)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = {mem[{mem_addr[11:2], 2'd3}], mem[{mem_addr[11:2], 2'd2}],
                      mem[{mem_addr[11:2], 2'd1}], mem[{mem_addr[11:2], 2'd0}]};
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (mem_wen[i]) mem[{mem_addr[11:2], 2'(i)}] <= mem_wdata[8*i +: 8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit spec_err(input tx_t x);
    int a = int'(x.addr);
    return x.size == 2'd3 || (x.size == 2'd1 && a % 2 != 0) || (x.size == 2'd2 && a % 4 != 0) || a > MEM - 4;
  endfunction

  task automatic ref_write(input int w, input tx_t x);
    if (x.we && !spec_err(x))
      for (int i = 0; i < nbytes(x.size); i++) ref_mem[int'(x.addr) + i] = x.wdata[8*i +: 8];
    ref_last = (w != 0);
  endtask

  task automatic set_req(input int m, input bit r, input tx_t x);
    if (m == 0) begin
      m0_req = r; m0_we = x.we; m0_size = x.size; m0_addr = x.addr; m0_wdata = x.wdata;
    end else begin
      m1_req = r; m1_we = x.we; m1_size = x.size; m1_addr = x.addr; m1_wdata = x.wdata;
    end
  endtask

  // one full IDLE -> ACCESS -> RESP -> IDLE transaction, requests already driven
  task automatic round(input int w, input logic [3:0] ewen, input logic [31:0] emaddr,
                       input logic [31:0] emwdata, input logic [31:0] erdata, input bit eerr, input string tag);
    @(posedge clk); #1;
    chk({tag, ":gnt"}, {30'd0, m1_gnt, m0_gnt}, (w != 0) ? 32'd2 : 32'd1);
    chk({tag, ":wen"}, {28'd0, mem_wen}, {28'd0, ewen});
    chk({tag, ":maddr"}, mem_addr, emaddr);
    chk({tag, ":mwdata"}, mem_wdata, emwdata);
    if (w != 0) m1_req = 0; else m0_req = 0;
    @(posedge clk); #1;
    chk({tag, ":rvalid"}, {28'd0, m1_rvalid, m0_rvalid, m1_gnt, m0_gnt}, (w != 0) ? 32'd8 : 32'd4);
    chk({tag, ":rdata"}, (w != 0) ? m1_rdata : m0_rdata, erdata);
    chk({tag, ":err"}, {31'd0, (w != 0) ? m1_err : m0_err}, {31'd0, eerr});
    chk({tag, ":other"}, (w != 0) ? (m0_rdata | {31'd0, m0_err}) : (m1_rdata | {31'd0, m1_err}), 32'd0);
    chk({tag, ":wen_resp"}, {28'd0, mem_wen}, 32'd0);
    @(posedge clk); #1;
    chk({tag, ":idle"}, {28'd0, m1_rvalid, m0_rvalid, m1_gnt, m0_gnt}, 32'd0);
  endtask

  task automatic model_round(input int w, input tx_t x, input string tag);
    int a = int'(x.addr);
    int n = nbytes(x.size);
    bit e = spec_err(x);
    logic [3:0] ewen = (x.we && !e) ? 4'(((1 << n) - 1) << (a % 4)) : 4'd0;
    logic [31:0] erd = 32'd0;
    if (!x.we && !e)
      for (int i = 0; i < n; i++) erd = erd | (32'(ref_mem[a + i]) << (8 * i));
    round(w, ewen, x.addr & ~32'd3, x.wdata << (8 * (a % 4)), erd, e, tag);
    ref_write(w, x);
  endtask

  function automatic tx_t rand_tx();
    tx_t x;
    x.we = 1'($urandom_range(0, 1));
    x.size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    x.addr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(MEM - 8, MEM + 8)) : 32'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0) x.addr = x.addr & ~32'(nbytes(x.size) - 1);
    x.wdata = $urandom;
    return x;
  endfunction

  initial begin
    int w;
    tx_t z;
    z = '{1'b0, 2'd0, 32'd0, 32'd0};
    for (int i = 0; i < MEM; i++) begin
      mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    #2;
    chk("reset_ctl", {18'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_wen, 4'd0}, 32'd0);
    chk("reset_data", m0_rdata | m1_rdata | mem_addr | mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // simultaneous requests for three rounds: m0, m1, m0
    for (int r = 0; r < 3; r++) begin
      set_req(0, 1'b1, '{1'b0, 2'd2, 32'h100, 32'd0});
      set_req(1, 1'b1, '{1'b0, 2'd2, 32'h104, 32'd0});
      model_round((r == 1) ? 1 : 0, (r == 1) ? '{1'b0, 2'd2, 32'h104, 32'd0} : '{1'b0, 2'd2, 32'h100, 32'd0},
                  $sformatf("tie%0d", r));
    end
    set_req(1, 1'b0, z);

    vt[0] = '{0, '{1'b1, 2'd2, 32'h10, 32'hDEADBEEF}, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    vt[1] = '{0, '{1'b0, 2'd0, 32'h11, 32'h0}, 4'h0, 32'h10, 32'h0, 32'h000000BE, 1'b0};
    vt[2] = '{1, '{1'b1, 2'd1, 32'h22, 32'hA5A5}, 4'hC, 32'h20, 32'hA5A50000, 32'h0, 1'b0};
    vt[3] = '{1, '{1'b0, 2'd1, 32'h22, 32'h0}, 4'h0, 32'h20, 32'h0, 32'h0000A5A5, 1'b0};
    vt[4] = '{0, '{1'b0, 2'd2, 32'h13, 32'h0}, 4'h0, 32'h10, 32'h0, 32'h0, 1'b1};
    vt[5] = '{1, '{1'b1, 2'd1, 32'h05, 32'h1234}, 4'h0, 32'h04, 32'h00123400, 32'h0, 1'b1};
    vt[6] = '{0, '{1'b1, 2'd3, 32'h08, 32'hFF}, 4'h0, 32'h08, 32'hFF, 32'h0, 1'b1};
    vt[7] = '{1, '{1'b1, 2'd2, 32'(MEM - 2), 32'h11223344}, 4'h0, 32'(MEM - 4), 32'h33440000, 32'h0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      set_req(vt[i].m, 1'b1, vt[i].x);
      round(vt[i].m, vt[i].wen, vt[i].maddr, vt[i].mwdata, vt[i].rdata, vt[i].err, $sformatf("vec%0d", i));
      ref_write(vt[i].m, vt[i].x);
    end

    // reset in the middle of a write's ACCESS cycle
    set_req(0, 1'b1, '{1'b1, 2'd2, 32'h40, 32'hCAFEF00D});
    @(posedge clk); #1;
    chk("rst:gnt", {31'd0, m0_gnt}, 32'd1);
    chk("rst:wen_before", {28'd0, mem_wen}, 32'hF);
    m0_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst:ctl", {18'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_wen, 4'd0}, 32'd0);
    chk("rst:data", m0_rdata | m1_rdata | mem_addr | mem_wdata, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst:no_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    end
    chk("rst:mem_kept", {mem[32'h43], mem[32'h42], mem[32'h41], mem[32'h40]},
        {ref_mem[32'h43], ref_mem[32'h42], ref_mem[32'h41], ref_mem[32'h40]});
    @(negedge clk);
    rst_n = 1'b1;
    ref_last = 1'b1;
    set_req(1, 1'b1, '{1'b0, 2'd2, 32'h40, 32'd0});
    model_round(1, '{1'b0, 2'd2, 32'h40, 32'd0}, "post_rst");

    // randomized traffic; a losing request stays up until granted
    pend[0] = 0;
    pend[1] = 0;
    for (int r = 0; r < 120; r++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 1) == 1) begin
          t[m] = rand_tx();
          pend[m] = 1;
        end
      if (!pend[0] && !pend[1]) begin
        t[0] = rand_tx();
        pend[0] = 1;
      end
      set_req(0, pend[0], t[0]);
      set_req(1, pend[1], t[1]);
      w = (pend[0] && pend[1]) ? int'(!ref_last) : int'(pend[1]);
      model_round(w, t[w], $sformatf("rnd%0d", r));
      pend[w] = 0;
    end
    set_req(0, 1'b0, z);
    set_req(1, 1'b0, z);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
